pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 81 ++++++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    // Controller state, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // Default number of MEM_WAIT cycles tolerated before a timeout error.
    localparam int unsigned DEFAULT_MEM_TIMEOUT = 15;

    // Wait counter only has to reach 15, the largest legal timeout.
    localparam int WAIT_CNT_W  = 4;
    localparam int STALL_CNT_W = 16;

    // Bundle of every pipeline control line driven by the controller.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } ctrl_t;

    // Pipeline frozen, every register loaded with a bubble.
    function automatic ctrl_t ctrl_bubble_all();
        ctrl_t c;
        c = '0;
        c.ifid_flush  = 1'b1;
        c.idex_flush  = 1'b1;
        c.exmem_flush = 1'b1;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

    // Normal flow: everything advances, nothing squashed.
    function automatic ctrl_t ctrl_run();
        ctrl_t c;
        c = '0;
        c.pc_en    = 1'b1;
        c.ifid_en  = 1'b1;
        c.idex_en  = 1'b1;
        c.exmem_en = 1'b1;
        return c;
    endfunction

    // Memory stall: upstream frozen, a bubble goes into MEM/WB.
    function automatic ctrl_t ctrl_mem_stall();
        ctrl_t c;
        c = '0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

    // Load-use stall: hold PC and IF/ID, insert a bubble into ID/EX.
    function automatic ctrl_t ctrl_load_use();
        ctrl_t c;
        c = '0;
        c.idex_en    = 1'b1;
        c.exmem_en   = 1'b1;
        c.idex_flush = 1'b1;
        return c;
    endfunction

    // Jump redirect: fetch continues from the target, younger work squashed.
    function automatic ctrl_t ctrl_jump();
        ctrl_t c;
        c = ctrl_run();
        c.ifid_flush  = 1'b1;
        c.idex_flush  = 1'b1;
        c.exmem_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: the load in ID/EX writes a register
// that the instruction in IF/ID is about to read.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    output logic       load_use
);

    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    always_comb begin
        load_use = 1'b0;
        if (idex_memread && (idex_rt != 5'd0) &&
            ((idex_rt == ifid_rs) || (idex_rt == ifid_rt))) begin
            load_use = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decides per cycle which pipeline registers
// load, which take a bubble, tracks memory-wait timeouts and counts stalls.
//
// Handshake: a data-memory access is outstanding while mem_req=1; the
// access completes in the cycle where mem_req=1 and mem_ready=1. Once the
// controller is waiting, only mem_ready is watched until completion.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    // Legal range 1..15.
    parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        startin,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        exmem_jump,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [1:0]  fsm_state
);

    localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_t                  state, state_n;
    logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_n;
    logic                    mem_err_n;
    logic                    load_use;
    logic                    mem_wait_req;
    logic                    stall_inc;
    ctrl_t                   ctrl;

    hazard_detect u_hazard_detect (
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .load_use     (load_use)
    );

    assign mem_wait_req = mem_req && !mem_ready;

    // Next-state, wait-counter and control decode; memory wait beats jump beats load-use.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        mem_err_n  = mem_err;
        ctrl       = ctrl_bubble_all();
        case (state)
            ST_IDLE: begin
                state_n    = ST_RUN;
                wait_cnt_n = '0;
            end
            ST_RUN: begin
                if (mem_wait_req) begin
                    ctrl       = ctrl_mem_stall();
                    state_n    = ST_MEM_WAIT;
                    wait_cnt_n = WAIT_CNT_W'(1);
                end else if (exmem_jump) begin
                    // A jump also squashes any load-use victim in IF/ID.
                    ctrl = ctrl_jump();
                end else if (load_use) begin
                    ctrl = ctrl_load_use();
                end else begin
                    ctrl = ctrl_run();
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl       = ctrl_run();
                    state_n    = ST_RUN;
                    wait_cnt_n = '0;
                end else begin
                    ctrl = ctrl_mem_stall();
                    if (wait_cnt == TIMEOUT_V) begin
                        state_n   = ST_HALT;
                        mem_err_n = 1'b1;
                    end else begin
                        wait_cnt_n = wait_cnt + WAIT_CNT_W'(1);
                    end
                end
            end
            ST_HALT: begin
                mem_err_n = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // Reset asserted: the pipeline must see bubbles everywhere right away.
        if (!startin) begin
            ctrl = ctrl_bubble_all();
        end
    end

    // Stalls count only while the pipeline is supposed to be flowing.
    assign stall_inc = ((state == ST_RUN) || (state == ST_MEM_WAIT)) &&
                       !ctrl.pc_en && (stall_cnt != STALL_MAX);

    // State, wait counter, sticky error and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!startin) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            mem_err  <= mem_err_n;
            if (stall_inc) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign fsm_state   = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int MT = 4;

  // ---------------- clock / reset block ----------------
  logic        clk;
  logic        startin;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        idex_memread, exmem_jump, mem_req, mem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [1:0]  fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk          (clk),
    .startin      (startin),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .exmem_jump   (exmem_jump),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .fsm_state    (fsm_state)
  );

  // ---------------- behavioural model ----------------
  // Pipeline condition as seen by the model: powered down, flowing,
  // waiting on memory for m_waited cycles, or dead after a timeout.
  localparam int P_IDLE = 0, P_FLOW = 1, P_WAIT = 2, P_DEAD = 3;
  int m_phase;
  int m_waited;
  bit m_err;
  int m_stall;

  // Control vector order: pc, ifid, idex, exmem enables, then ifid, idex, exmem, memwb flushes.
  function automatic logic [7:0] model_out();
    bit lu;
    lu = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (!startin || m_phase == P_IDLE || m_phase == P_DEAD) return 8'b0000_1111;
    if (m_phase == P_WAIT) return mem_ready ? 8'b1111_0000 : 8'b0000_0001;
    if (mem_req && !mem_ready) return 8'b0000_0001;
    if (exmem_jump)            return 8'b1111_1110;
    if (lu)                    return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  task automatic model_clock(input logic [7:0] o);
    if (!startin) begin
      m_phase = P_IDLE; m_waited = 0; m_err = 0; m_stall = 0;
      return;
    end
    if ((m_phase == P_FLOW || m_phase == P_WAIT) && o[7] == 1'b0 && m_stall < 65535)
      m_stall++;
    case (m_phase)
      P_IDLE: m_phase = P_FLOW;
      P_FLOW: if (mem_req && !mem_ready) begin m_phase = P_WAIT; m_waited = 1; end
      P_WAIT: begin
        if (mem_ready) begin m_phase = P_FLOW; m_waited = 0; end
        else if (m_waited == MT) begin m_phase = P_DEAD; m_err = 1; end
        else m_waited++;
      end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] act_out();
    return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, memwb_flush};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit st, input int rs, input int rt, input bit mr,
                       input int irt, input bit j, input bit rq, input bit rdy);
    startin      = st;
    ifid_rs      = 5'(rs);
    ifid_rt      = 5'(rt);
    idex_memread = mr;
    idex_rt      = 5'(irt);
    exmem_jump   = j;
    mem_req      = rq;
    mem_ready    = rdy;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic step(input bit chk, input string tag);
    logic [7:0] e;
    logic [7:0] a;
    @(negedge clk);
    e = model_out();
    exp_q.push_back(e);
    if (chk) begin
      e = exp_q.pop_front();
      a = act_out();
      n_checks++;
      assert (a === e) else begin
        n_fail++;
        $error("FAIL %s ctrl: got %b expected %b", tag, a, e);
      end
      n_checks++;
      assert (stall_cnt === 16'(m_stall)) else begin
        n_fail++;
        $error("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, m_stall);
      end
      n_checks++;
      assert (mem_err === m_err) else begin
        n_fail++;
        $error("FAIL %s mem_err: got %b expected %b", tag, mem_err, m_err);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    model_clock(e);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_phase = P_IDLE; m_waited = 0; m_err = 0; m_stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;

    // Reset held, then released: one idle cycle, then flowing.
    step(1, "reset0");
    step(1, "reset1");
    drive(1, 1, 2, 0, 0, 0, 0, 1);
    step(1, "idle_after_reset");
    step(1, "first_run");

    // Load-use on rs, then it clears; rt=0 load never stalls; match on rt.
    drive(1, 5, 7, 1, 5, 0, 0, 1);
    step(1, "loaduse_rs");
    drive(1, 5, 7, 0, 5, 0, 0, 1);
    step(1, "loaduse_cleared");
    drive(1, 0, 0, 1, 0, 0, 0, 1);
    step(1, "loaduse_r0");
    drive(1, 3, 9, 1, 9, 0, 0, 1);
    step(1, "loaduse_rt");
    drive(1, 3, 9, 0, 0, 0, 0, 1);
    step(1, "after_loaduse_rt");

    // Memory wait: ready low for three cycles, then high.
    drive(1, 1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, "memwait_low");
    drive(1, 1, 2, 0, 0, 0, 1, 1);
    step(1, "memwait_ready");
    drive(1, 1, 2, 0, 0, 0, 0, 1);
    step(1, "memwait_after");

    // Load-use together with a jump: jump wins, no stall counted.
    drive(1, 6, 6, 1, 6, 1, 0, 1);
    step(1, "loaduse_and_jump");
    drive(1, 6, 6, 0, 0, 1, 0, 1);
    step(1, "jump_only");
    drive(1, 6, 6, 0, 0, 0, 0, 1);
    step(1, "post_jump");

    // Jump during MEM_WAIT is ignored.
    drive(1, 1, 2, 0, 0, 0, 1, 0);
    step(1, "enter_wait");
    drive(1, 1, 2, 0, 0, 1, 1, 0);
    step(1, "jump_in_wait");
    drive(1, 1, 2, 0, 0, 0, 1, 1);
    step(1, "wait_done");

    // Timeout: ready never comes; after four MEM_WAIT cycles it halts for good.
    drive(1, 1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, "timeout_run");
    drive(1, 4, 4, 1, 4, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, "halt_hold");
    n_checks++;
    assert (mem_err === 1'b1) else begin
      n_fail++;
      $error("FAIL halt_err: got %b expected 1", mem_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, "halt_reset");
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, "halt_recover_idle");
    step(1, "halt_recover_run");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) != 0);
      step(1, "random");
    end

    // Clean restart, then sustained load-use stalls drive stall_cnt to saturation.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, "sat_reset");
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, "sat_idle");
    drive(1, 8, 1, 1, 8, 0, 0, 1);
    for (int i = 0; i < 65540; i++)
      step((i % 8192 == 0) || (i > 65530), "saturate");
    n_checks++;
    assert (stall_cnt === 16'hFFFF) else begin
      n_fail++;
      $error("FAIL sat_value: got %h expected ffff", stall_cnt);
    end

    // Reset in the middle of a memory wait clears everything.
    drive(1, 1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, "wait_before_reset");
    drive(0, 1, 2, 0, 0, 0, 1, 0);
    step(1, "reset_in_wait");
    drive(1, 1, 2, 0, 0, 0, 0, 1);
    step(1, "after_wait_reset_idle");
    step(1, "after_wait_reset_run");
    n_checks++;
    assert (stall_cnt === 16'd0) else begin
      n_fail++;
      $error("FAIL reset_clear_stall: got %0d expected 0", stall_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
